pkt_router_multi: RTL and testbench

Parametrised successor of the 3-port packet router. It accepts a framed byte stream (header, payload, parity) on one input and steers each packet into one of NUM_CH per-channel FIFOs chosen by the header address. The block checks parity and drops packets addressed to a non-existent channel. A hung reader has its channel flushed after a timeout. It sits between the chip input pads and the per-channel consumers.

---
 rtl/pkt_router_pkg.sv | 14 +
 rtl/pkt_router_fifo.sv | 50 +++++
 rtl/pkt_router_multi.sv | 147 ++++++++++++++
 tb/tb_pkt_router_multi.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pkt_router_pkg.sv
// pkt_router_pkg: shared state encoding, header field positions and width helpers
package pkt_router_pkg;
  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, DROP} state_e;
  localparam int ADDR_LSB = 0;
  function automatic int len_lsb(input int addr_w);
    return addr_w;
  endfunction
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pkt_router_fifo.sv
// pkt_router_fifo: per-channel FIFO with occupancy counter, flush and registered read data
module pkt_router_fifo
  import pkt_router_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] dout
);
  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam int CW = cnt_w(FIFO_DEPTH);
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic we, re;
  assign full  = cnt_q == CW'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
  assign we    = wr && !full;
  assign re    = rd && !empty;
  assign dout  = dout_q;
  always_comb begin
    wp_d   = flush ? '0 : wp_q + PW'(we);
    rp_d   = flush ? '0 : rp_q + PW'(re);
    cnt_d  = flush ? '0 : cnt_q + CW'(we) - CW'(re);
    dout_d = flush ? '0 : re ? mem_q[rp_q] : dout_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  always_ff @(posedge clk)
    if (we && !flush) mem_q[wp_q] <= din;
endmodule

// File: rtl/pkt_router_multi.sv
// pkt_router_multi: framed byte stream router into NUM_CH FIFOs with parity check and timeout flush.
// Optional payload length check enabled by defining PKT_ROUTER_LEN_CHECK_EN (adds err_len).
module pkt_router_multi
  import pkt_router_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT = 30
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     packet_valid,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     busy,
  input  logic [NUM_CH-1:0]        read_enb,
  output logic [NUM_CH-1:0]        vld_out,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic                     err,
  output logic                     err_addr,
  output logic [NUM_CH-1:0]        soft_reset
`ifdef PKT_ROUTER_LEN_CHECK_EN
  ,
  output logic                     err_len
`endif
);
  localparam int NA = 2 ** ADDR_W;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] sel_q, sel_d, addr, tgt;
  logic [DATA_W-1:0] par_q, par_d, pbyte_q, pbyte_d;
  logic err_addr_q, err_addr_d;
  logic [NUM_CH-1:0] full, empty, wr, flush, soft_reset_q;
  logic [NA-1:0] full_x, flush_x;
  logic accept, valid_addr, we, flush_t, len_bad;
`ifdef PKT_ROUTER_LEN_CHECK_EN
  localparam int LW = DATA_W - ADDR_W;
  logic [LW-1:0] len_q, len_d, lcnt_q, lcnt_d;
  assign len_bad = lcnt_q != len_q;
  assign err_len = state_q == CHECK && len_bad;
`else
  assign len_bad = 1'b0;
`endif
  assign addr       = data_in[ADDR_LSB +: ADDR_W];
  assign valid_addr = int'(addr) < NUM_CH;
  assign tgt        = state_q == IDLE ? addr : sel_q;
  assign full_x     = NA'(full);
  assign flush_x    = NA'(flush);
  assign flush_t    = flush_x[tgt];
  assign busy       = state_q == IDLE    ? packet_valid && valid_addr && full_x[addr] :
                      state_q == PAYLOAD ? full_x[sel_q] : state_q == CHECK;
  assign accept     = !busy;
  assign err        = state_q == CHECK && (par_q != pbyte_q || len_bad);
  assign err_addr   = err_addr_q;
  assign soft_reset = soft_reset_q;
  assign vld_out    = ~empty;
  // A flush of the target channel mid-packet discards the rest of that packet via DROP
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    par_d      = par_q;
    pbyte_d    = pbyte_q;
    err_addr_d = 1'b0;
    we         = 1'b0;
`ifdef PKT_ROUTER_LEN_CHECK_EN
    len_d      = len_q;
    lcnt_d     = lcnt_q;
`endif
    case (state_q)
      IDLE: if (accept && packet_valid) begin
        sel_d = addr;
        par_d = data_in;
`ifdef PKT_ROUTER_LEN_CHECK_EN
        len_d  = data_in[len_lsb(ADDR_W) +: LW];
        lcnt_d = '0;
`endif
        if (!valid_addr) begin
          err_addr_d = 1'b1;
          state_d    = DROP;
        end else begin
          we      = 1'b1;
          state_d = flush_t ? DROP : PAYLOAD;
        end
      end
      PAYLOAD: if (accept) begin
        we = 1'b1;
        if (packet_valid) begin
          par_d   = par_q ^ data_in;
          state_d = flush_t ? DROP : PAYLOAD;
`ifdef PKT_ROUTER_LEN_CHECK_EN
          lcnt_d  = lcnt_q + 1'b1;
`endif
        end else begin
          pbyte_d = data_in;
          state_d = flush_t ? IDLE : CHECK;
        end
      end else if (flush_t) state_d = DROP;
      DROP: if (!packet_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    for (int c = 0; c < NUM_CH; c++) wr[c] = we && tgt == ADDR_W'(c);
  end
  always_ff @(posedge clk)
    if (resetn) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      par_q        <= '0;
      pbyte_q      <= '0;
      err_addr_q   <= 1'b0;
      soft_reset_q <= '0;
`ifdef PKT_ROUTER_LEN_CHECK_EN
      len_q        <= '0;
      lcnt_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      par_q        <= par_d;
      pbyte_q      <= pbyte_d;
      err_addr_q   <= err_addr_d;
      soft_reset_q <= flush;
`ifdef PKT_ROUTER_LEN_CHECK_EN
      len_q        <= len_d;
      lcnt_q       <= lcnt_d;
`endif
    end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [TW-1:0] tmo_q, tmo_d;
    assign flush[c] = vld_out[c] && !read_enb[c] && tmo_q == TW'(TIMEOUT - 1);
    assign tmo_d    = (!vld_out[c] || read_enb[c] || flush[c]) ? '0 : tmo_q + 1'b1;
    always_ff @(posedge clk)
      if (resetn) tmo_q <= '0;
      else tmo_q <= tmo_d;
    pkt_router_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .rst(resetn),
      .wr(wr[c]),
      .rd(read_enb[c]),
      .flush(flush[c]),
      .din(data_in),
      .full(full[c]),
      .empty(empty[c]),
      .dout(data_out[c*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_pkt_router_multi.sv
// tb_pkt_router_multi: table-driven and hand-sequenced checks of the router (NUM_CH=3, FIFO_DEPTH=4)
module tb_pkt_router_multi;
  logic clk, resetn, packet_valid, busy, err, err_addr;
  logic [7:0] data_in;
  logic [2:0] read_enb, vld_out, soft_reset;
  logic [23:0] data_out;
  int checks = 0, errors = 0;

  typedef struct {
    logic pv; logic [7:0] din; logic [2:0] rd;
    logic busy; logic [2:0] vld; logic [23:0] dout; logic err; logic erra;
  } vec_t;
  vec_t tv[$];

  pkt_router_multi #(.DATA_W(8), .NUM_CH(3), .ADDR_W(2), .FIFO_DEPTH(4), .TIMEOUT(30)) dut (
    .clk(clk), .resetn(resetn), .packet_valid(packet_valid), .data_in(data_in), .busy(busy),
    .read_enb(read_enb), .vld_out(vld_out), .data_out(data_out), .err(err), .err_addr(err_addr),
    .soft_reset(soft_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input logic p, input logic [7:0] d, input logic [2:0] r, input logic b,
                             input logic [2:0] vl, input logic [23:0] o, input logic e, input logic ea);
    vec_t t;
    t.pv = p; t.din = d; t.rd = r; t.busy = b; t.vld = vl; t.dout = o; t.err = e; t.erra = ea;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic p, input logic [7:0] d, input logic [2:0] r, input logic rs);
    @(posedge clk);
    #1;
    packet_valid = p; data_in = d; read_enb = r; resetn = rs;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] bq [8];
    logic [7:0] got [$];
    int idx, first, np;
    logic pend, e;
    resetn = 1'b1; packet_valid = 1'b0; data_in = '0; read_enb = '0;
    repeat (2) @(posedge clk);
    cyc(0, 8'h00, 3'b000, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vld", vld_out, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_err", err, 0);
    chk("rst_erra", err_addr, 0);
    chk("rst_soft", soft_reset, 0);

    // basic route to ch1 with concurrent reads, good parity 0D
    tv.push_back(v(1, 8'h0D, 3'b000, 0, 3'b000, 24'h000000, 0, 0));
    tv.push_back(v(1, 8'h11, 3'b000, 0, 3'b010, 24'h000000, 0, 0));
    tv.push_back(v(1, 8'h22, 3'b000, 0, 3'b010, 24'h000000, 0, 0));
    tv.push_back(v(1, 8'h33, 3'b010, 0, 3'b010, 24'h000000, 0, 0));
    tv.push_back(v(0, 8'h0D, 3'b010, 0, 3'b010, 24'h000D00, 0, 0));
    tv.push_back(v(0, 8'h00, 3'b010, 1, 3'b010, 24'h001100, 0, 0));
    tv.push_back(v(0, 8'h00, 3'b010, 0, 3'b010, 24'h002200, 0, 0));
    tv.push_back(v(0, 8'h00, 3'b010, 0, 3'b010, 24'h003300, 0, 0));
    tv.push_back(v(0, 8'h00, 3'b010, 0, 3'b000, 24'h000D00, 0, 0));
    tv.push_back(v(0, 8'h00, 3'b000, 0, 3'b000, 24'h000D00, 0, 0));
    // bad parity 00; FIFO fills so the parity beat waits for one read
    tv.push_back(v(1, 8'h0D, 3'b000, 0, 3'b000, 24'h000D00, 0, 0));
    tv.push_back(v(1, 8'h11, 3'b000, 0, 3'b010, 24'h000D00, 0, 0));
    tv.push_back(v(1, 8'h22, 3'b000, 0, 3'b010, 24'h000D00, 0, 0));
    tv.push_back(v(1, 8'h33, 3'b000, 0, 3'b010, 24'h000D00, 0, 0));
    tv.push_back(v(0, 8'h00, 3'b000, 1, 3'b010, 24'h000D00, 0, 0));
    tv.push_back(v(0, 8'h00, 3'b010, 1, 3'b010, 24'h000D00, 0, 0));
    tv.push_back(v(0, 8'h00, 3'b000, 0, 3'b010, 24'h000D00, 0, 0));
    tv.push_back(v(0, 8'h00, 3'b000, 1, 3'b010, 24'h000D00, 1, 0));
    tv.push_back(v(0, 8'h00, 3'b010, 0, 3'b010, 24'h000D00, 0, 0));
    tv.push_back(v(0, 8'h00, 3'b010, 0, 3'b010, 24'h001100, 0, 0));
    tv.push_back(v(0, 8'h00, 3'b010, 0, 3'b010, 24'h002200, 0, 0));
    tv.push_back(v(0, 8'h00, 3'b010, 0, 3'b010, 24'h003300, 0, 0));
    tv.push_back(v(0, 8'h00, 3'b000, 0, 3'b000, 24'h000000, 0, 0));
    // invalid address 3 dropped, then a valid packet to ch0
    tv.push_back(v(1, 8'h07, 3'b000, 0, 3'b000, 24'h000000, 0, 0));
    tv.push_back(v(1, 8'hAA, 3'b000, 0, 3'b000, 24'h000000, 0, 1));
    tv.push_back(v(0, 8'h55, 3'b000, 0, 3'b000, 24'h000000, 0, 0));
    tv.push_back(v(1, 8'h04, 3'b000, 0, 3'b000, 24'h000000, 0, 0));
    tv.push_back(v(1, 8'h5A, 3'b000, 0, 3'b001, 24'h000000, 0, 0));
    tv.push_back(v(0, 8'h5E, 3'b000, 0, 3'b001, 24'h000000, 0, 0));
    tv.push_back(v(0, 8'h00, 3'b001, 1, 3'b001, 24'h000000, 0, 0));
    tv.push_back(v(0, 8'h00, 3'b001, 0, 3'b001, 24'h000004, 0, 0));
    tv.push_back(v(0, 8'h00, 3'b001, 0, 3'b001, 24'h00005A, 0, 0));
    tv.push_back(v(0, 8'h00, 3'b001, 0, 3'b000, 24'h00005E, 0, 0));
    tv.push_back(v(0, 8'h00, 3'b000, 0, 3'b000, 24'h00005E, 0, 0));
    foreach (tv[i]) begin
      cyc(tv[i].pv, tv[i].din, tv[i].rd, 0);
      chk($sformatf("v%0d_busy", i), busy, tv[i].busy);
      chk($sformatf("v%0d_vld", i), vld_out, tv[i].vld);
      chk($sformatf("v%0d_dout", i), data_out, tv[i].dout);
      chk($sformatf("v%0d_err", i), err, tv[i].err);
      chk($sformatf("v%0d_erra", i), err_addr, tv[i].erra);
      chk($sformatf("v%0d_soft", i), soft_reset, 0);
    end

    // back-pressure: 6-payload packet to ch0, reads start late
    bq = '{8'h18, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h1F};
    idx = 0; pend = 0; e = 0;
    for (int c = 0; c < 80 && got.size() < 8; c++) begin
      cyc(idx < 7, idx < 8 ? bq[idx] : 8'h00, c >= 8 ? 3'b001 : 3'b000, 0);
      if (c == 4) begin
        chk("bp_busy", busy, 1);
        chk("bp_idx", idx, 4);
      end
      if (pend) got.push_back(data_out[7:0]);
      pend = read_enb[0] && vld_out[0];
      e |= err;
      if (!busy && idx < 8) idx++;
    end
    chk("bp_cnt", got.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("bp_d%0d", i), got[i], bq[i]);
    chk("bp_err", e, 0);
    cyc(0, 8'h00, 3'b000, 0);
    chk("bp_empty", vld_out[0], 0);

    // timeout on ch2 with a packet in flight
    e = 0; first = -1; np = 0;
    for (int c = 0; c < 36; c++) begin
      cyc(c < 33, c == 0 ? 8'h0A : c == 1 ? 8'h77 : c < 33 ? 8'h88 : 8'h5C, c == 1 ? 3'b100 : 3'b000, 0);
      e |= err;
      if (soft_reset[2]) begin
        np++;
        if (first < 0) first = c;
      end
      if (c == 31) begin
        chk("tmo_vld_pre", vld_out[2], 1);
        chk("tmo_dout_pre", data_out[23:16], 8'h0A);
      end
      if (c == 32) begin
        chk("tmo_vld", vld_out[2], 0);
        chk("tmo_dout", data_out[23:16], 0);
        chk("tmo_busy", busy, 0);
      end
    end
    chk("tmo_first", first, 32);
    chk("tmo_pulses", np, 1);
    chk("tmo_err", e, 0);
    chk("tmo_vld_end", vld_out[2], 0);

    // write+read at FIFO_DEPTH-1 keeps count, then reset mid-packet
    cyc(1, 8'h01, 3'b000, 0);
    cyc(1, 8'h10, 3'b000, 0);
    cyc(1, 8'h20, 3'b000, 0);
    for (int c = 0; c < 4; c++) begin
      cyc(1, 8'h40 + 8'(c), 3'b010, 0);
      chk($sformatf("rw_busy%0d", c), busy, 0);
      chk($sformatf("rw_vld%0d", c), vld_out[1], 1);
    end
    cyc(1, 8'h77, 3'b000, 1);
    cyc(0, 8'h00, 3'b000, 0);
    chk("mr_busy", busy, 0);
    chk("mr_vld", vld_out, 0);
    chk("mr_dout", data_out, 0);
    chk("mr_err", err, 0);
    chk("mr_erra", err_addr, 0);
    chk("mr_soft", soft_reset, 0);
    cyc(1, 8'h07, 3'b000, 0);
    cyc(0, 8'h00, 3'b000, 0);
    chk("mr_erra_pulse", err_addr, 1);
    cyc(0, 8'h00, 3'b000, 0);
    chk("mr_erra_end", err_addr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
